// File: rtl/mc10_pkg.sv
// Shared types and constants for the MC-10 bank-switched RAM expansion controller.
package mc10_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        HOLD    = 3'd4
    } ramx_state_t;

    // Value presented on the OR-merged expansion data lines when not driving.
    localparam logic [7:0] EXP_IDLE     = 8'h00;
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/mc10_ram_banker_e_edge_det.sv
// Registers the CPU E clock into the clk_4 domain and flags its rising and falling edges.
module e_edge_det (
    input  logic clk_4,
    input  logic reset,
    input  logic e_clk,
    output logic e_rise,
    output logic e_fall
);

    logic cur_q;
    logic prev_q;

    // Two-stage history of E: cur_q is the registered sample, prev_q the one before it.
    always_ff @(posedge clk_4) begin
        if (reset) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= e_clk;
            prev_q <= cur_q;
        end
    end

    assign e_rise = cur_q & ~prev_q;
    assign e_fall = ~cur_q & prev_q;

endmodule

// File: rtl/mc10_ram_banker.sv
// MC-10 bank-switched RAM expansion controller; define MC10_BANK_READBACK_EN to make
// the bank register readable as {err, zero padding, bank}.
module mc10_ram_banker
    import mc10_pkg::*;
#(
    parameter int          BANK_BITS     = 2,
    parameter logic [15:0] WIN_BASE      = 16'h5000,
    parameter int          WIN_LOG2      = 14,
    parameter logic [15:0] BANK_REG_ADDR = 16'hBF80,
    parameter int          TIMEOUT       = 3
) (
    input  logic                          clk_4,
    input  logic                          reset,
    input  logic                          e_clk,
    input  logic [15:0]                   cpu_addr,
    input  logic [7:0]                    cpu_dout,
    input  logic                          cpu_rw,
    output logic                          exp_sel,
    output logic [7:0]                    exp_data,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [BANK_BITS+WIN_LOG2-1:0] mem_addr,
    output logic [7:0]                    mem_wdata,
    input  logic [7:0]                    mem_rdata,
    input  logic                          mem_ack,
    output logic [BANK_BITS-1:0]          bank,
    output logic                          err
);

    localparam int          AW      = BANK_BITS + WIN_LOG2;
    localparam logic [16:0] WIN_END = {1'b0, WIN_BASE} + (17'd1 << WIN_LOG2);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    logic e_rise;
    logic e_fall;

    e_edge_det u_e_edge_det (
        .clk_4  (clk_4),
        .reset  (reset),
        .e_clk  (e_clk),
        .e_rise (e_rise),
        .e_fall (e_fall)
    );

    ramx_state_t          state_q,     state_d;
    logic [AW-1:0]        mem_addr_q,  mem_addr_d;
    logic                 mem_req_q,   mem_req_d;
    logic                 mem_we_q,    mem_we_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic [7:0]           hold_q,      hold_d;
    logic [BANK_BITS-1:0] bank_q,      bank_d;
    logic                 err_q,       err_d;
    logic [7:0]           wait_q,      wait_d;
    logic                 wr_bank_q,   wr_bank_d;

    logic                 win_hit_s;
    logic                 reg_hit_s;
    logic [15:0]          off_full_s;
    logic [WIN_LOG2-1:0]  offset_s;
    logic [7:0]           readback_s;

    // Address decode is purely combinational on the live CPU address.
    always_comb begin
        win_hit_s  = ({1'b0, cpu_addr} >= {1'b0, WIN_BASE}) && ({1'b0, cpu_addr} < WIN_END);
        reg_hit_s  = (cpu_addr == BANK_REG_ADDR);
        off_full_s = cpu_addr - WIN_BASE;
        offset_s   = off_full_s[WIN_LOG2-1:0];
    end

    assign exp_sel = win_hit_s | reg_hit_s;

    // Value returned when the CPU reads the bank register.
    always_comb begin
        readback_s = EXP_IDLE;
`ifdef MC10_BANK_READBACK_EN
        readback_s    = 8'(bank_q);
        readback_s[7] = err_q;
`else
        readback_s = EXP_IDLE;
`endif
    end

    // Next-state and datapath decisions for the bus-cycle FSM.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        bank_d      = bank_q;
        err_d       = err_q;
        wait_d      = wait_q;
        wr_bank_d   = wr_bank_q;

        case (state_q)
            // HOLD keeps driving read data until the next E rise, which is decoded like IDLE.
            IDLE, HOLD: begin
                if (e_rise) begin
                    state_d = IDLE;
                    if (reg_hit_s) begin
                        wr_bank_d = 1'b1;
                        if (cpu_rw) begin
                            hold_d  = readback_s;
                            state_d = HOLD;
                        end else begin
                            state_d = WR_WAIT;
                        end
                    end else if (win_hit_s) begin
                        wr_bank_d  = 1'b0;
                        mem_addr_d = {bank_q, offset_s};
                        if (cpu_rw) begin
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                            wait_d    = 8'd0;
                            state_d   = RD_REQ;
                        end else begin
                            state_d = WR_WAIT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            WR_WAIT: begin
                if (e_fall) begin
                    if (wr_bank_q) begin
                        bank_d  = cpu_dout[BANK_BITS-1:0];
                        state_d = IDLE;
                    end else begin
                        mem_wdata_d = cpu_dout;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        wait_d      = 8'd0;
                        state_d     = WR_REQ;
                    end
                end else begin
                    state_d = WR_WAIT;
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    hold_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = HOLD;
                end else if (wait_q == TO_LAST) begin
                    hold_d    = TIMEOUT_FILL;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = HOLD;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (wait_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // A new CPU access while the memory port is still busy cannot be serviced.
        if (e_rise && ((state_q == RD_REQ) || (state_q == WR_REQ))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_4) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            hold_q      <= EXP_IDLE;
            bank_q      <= '0;
            err_q       <= 1'b0;
            wait_q      <= 8'd0;
            wr_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            bank_q      <= bank_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            wr_bank_q   <= wr_bank_d;
        end
    end

    assign exp_data  = ((state_q == HOLD) && exp_sel) ? hold_q : EXP_IDLE;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bank      = bank_q;
    assign err       = err_q;

endmodule

// File: doc/mc10_ram_banker.md
# mc10_ram_banker

Bank-switched RAM expansion controller for the MC-10 expansion connector, running on `clk_4`. It tracks the CPU E clock, decodes a parametrised address window and bank-select register, and asserts the expansion select so the internal decoder is inhibited. It translates each hit into a request/acknowledge transaction on a wide external memory port, for example SDRAM behind an arbiter. Read data goes back onto the expansion data lines, which are OR-merged into the CPU data bus.

## Interface
Parameters:
- `BANK_BITS`, 2: bank register width; expansion memory holds 2^BANK_BITS windows.
- `WIN_BASE`, 16'h5000: first CPU address of the window.
- `WIN_LOG2`, 14: window size is 2^WIN_LOG2 bytes; window is `WIN_BASE` .. `WIN_BASE`+2^WIN_LOG2-1.
- `BANK_REG_ADDR`, 16'hBF80: CPU address of the bank register.
- `TIMEOUT`, 3: maximum `clk_4` cycles from `mem_req` to `mem_ack`.

Ports:
- `clk_4` in 1: block clock.
- `reset` in 1: synchronous, active-high.
- `e_clk` in 1: CPU E clock, sampled on `clk_4`.
- `cpu_addr` in 16: CPU address.
- `cpu_dout` in 8: CPU write data.
- `cpu_rw` in 1: 1 = read.
- `exp_sel` out 1: 1 inhibits internal memory/I/O decode.
- `exp_data` out 8: read data; 8'h00 whenever not driving.
- `mem_req` out 1: external memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out BANK_BITS+WIN_LOG2: external memory address.
- `mem_wdata` out 8: write data.
- `mem_rdata` in 8: read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse.
- `bank` out BANK_BITS: current bank.
- `err` out 1: sticky timeout flag.

## Operation
- E edges come from a registered copy of `e_clk`. Rise means prev=0 and cur=1. Fall means prev=1 and cur=0.
- Hit decode is combinational on the live `cpu_addr`. `exp_sel` = window hit or bank-register hit, for any `cpu_rw`.
- Offset = (`cpu_addr` − `WIN_BASE`) truncated to `WIN_LOG2` bits. `mem_addr` = {bank, offset}.
- FSM states: IDLE, RD_REQ, WR_WAIT, WR_REQ, HOLD.
  - IDLE: on E rise with a window hit:
    - read: latch `mem_addr`, set `mem_req`=1 and `mem_we`=0, go to RD_REQ.
    - write: latch `mem_addr`, go to WR_WAIT.
  - IDLE: on E rise with a bank-register hit:
    - read: go to HOLD. `exp_data` = readback value (see Configuration).
    - write: go to WR_WAIT.
  - WR_WAIT: on E fall, capture `cpu_dout`.
    - Bank register: load `bank` with `cpu_dout[BANK_BITS-1:0]`, go to IDLE.
    - Window: set `mem_wdata`, `mem_req`=1 and `mem_we`=1, go to WR_REQ.
  - RD_REQ: on `mem_ack`, latch `mem_rdata` into the read holding register, drop `mem_req`, go to HOLD.
  - WR_REQ: on `mem_ack`, drop `mem_req`, go to IDLE.
  - HOLD: drive `exp_data` = holding register while `exp_sel`=1. Go to IDLE on the next E rise, and in that same cycle evaluate the new access as IDLE would.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1.
- Timeout: if the wait in RD_REQ or WR_REQ reaches `TIMEOUT` cycles without `mem_ack`:
  - drop `mem_req` and set `err`;
  - a read then returns 8'hFF through HOLD;
  - a write is dropped.
- A `mem_ack` arriving while not in RD_REQ or WR_REQ is ignored.
- `err` is cleared only by `reset`.

## Timing
- Reset values:
  - `exp_data`=8'h00, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `bank`=0, `err`=0, FSM in IDLE.
  - `exp_sel` follows decode combinationally.
- Read latency: `mem_req` rises 1 cycle after the E-rise sample. `exp_data` is valid 1 cycle after `mem_ack`. A zero-wait-state memory gives data 3 cycles after E rise, before E fall.
- Write: `mem_req` rises 1 cycle after the E-fall sample.
- Reset mid-transaction drops `mem_req` the following cycle. No ack is awaited.
- If an E rise arrives while the FSM is in RD_REQ or WR_REQ, the new access is not serviced and `err` is set.

## Configuration
- `MC10_BANK_READBACK_EN`: the bank register is readable.
  - Defined: a read of `BANK_REG_ADDR` returns {`err`, zero padding, `bank`}.
  - Undefined: a read of `BANK_REG_ADDR` returns 8'h00, but `exp_sel` is still asserted.

## Structure
- Package `mc10_pkg` holds:
  - the FSM state enum `ramx_state_t`;
  - the bus-idle constant `EXP_IDLE` = 8'h00;
  - the timeout-fill constant 8'hFF.
- Sub-module `e_edge_det`: registers `e_clk` and produces the one-cycle `e_rise` and `e_fall` pulses.

## Test plan
- Write 8'h03 to 16'hBF80, then write 8'hA5 to 16'h5000 → `mem_req` with `mem_we`=1, `mem_addr`={2'b11, 14'h0000}, `mem_wdata`=8'hA5.
- Read 16'h8FFF with bank 1 and ack returning 8'h5A → `mem_addr`={2'b01, 14'h3FFF}, `exp_data`=8'h5A, `exp_sel`=1.
- Read 16'h4FFF or 16'h9000 → `exp_sel`=0, `exp_data`=8'h00, no `mem_req`.
- Read with `mem_ack` withheld → `mem_req` drops after `TIMEOUT`, `exp_data`=8'hFF, `err`=1 until `reset`.
- Read 16'hBF80 with bank=2 and `err`=0 → 8'h02 with `MC10_BANK_READBACK_EN`, 8'h00 without.
- Assert `reset` while in RD_REQ → `mem_req`=0 next cycle, `bank`=0, FSM in IDLE.
